// File: rtl/gravador_sequencia_16x4_if.sv
// Bundle between the sequence recorder and its driver: button/start inputs,
// the read port and the status outputs.
interface gravador_sequencia_16x4_if;
  logic       iniciar;
  logic [3:0] botoes;
  logic [3:0] rd_address;
  logic [3:0] rd_data;
  logic [4:0] quantidade;
  logic       jogada_feita;
  logic       erro_jogada;
  logic       cheio;
  logic       gravando;

  modport master (
    output iniciar, botoes, rd_address,
    input  rd_data, quantidade, jogada_feita, erro_jogada, cheio, gravando
  );

  modport slave (
    input  iniciar, botoes, rd_address,
    output rd_data, quantidade, jogada_feita, erro_jogada, cheio, gravando
  );
endinterface

// File: rtl/gravador_sequencia_16x4.sv
// Records one-hot button presses into a 16x4 memory, one word per press,
// with a registered read port for replay/compare.
//
// state    | meaning
// INICIAL  | idle, waiting for iniciar
// ESPERA   | recording, buttons released, waiting for a press
// REGISTRA | writing the latched press, quantidade increments
// REJEITA  | non-one-hot press seen, pulse erro_jogada
// SOLTA    | waiting for all buttons to be released
// CHEIO    | 16 words stored, presses ignored until iniciar
module gravador_sequencia_16x4 (
  input logic                        clock,
  input logic                        reset,
  gravador_sequencia_16x4_if.slave   bus
);

  localparam logic [2:0] INICIAL  = 3'd0;
  localparam logic [2:0] ESPERA   = 3'd1;
  localparam logic [2:0] REGISTRA = 3'd2;
  localparam logic [2:0] REJEITA  = 3'd3;
  localparam logic [2:0] SOLTA    = 3'd4;
  localparam logic [2:0] CHEIO    = 3'd5;

  logic [2:0] estado_q, estado_d;
  logic [4:0] quantidade_q, quantidade_d;
  logic [3:0] dado_q, dado_d;
  logic [3:0] rd_data_q, rd_data_d;
  logic [3:0] mem_q [16];
  logic       escreve;
  logic       botoes_zero;
  logic       botoes_onehot;
  logic [2:0] estado_inicio;

  assign botoes_zero   = (bus.botoes == 4'b0000);
  assign botoes_onehot = !botoes_zero && ((bus.botoes & (bus.botoes - 4'd1)) == 4'b0000);
  // A button already held at start must be released before anything is captured.
  assign estado_inicio = botoes_zero ? ESPERA : SOLTA;

  always_comb begin
    estado_d     = estado_q;
    quantidade_d = quantidade_q;
    dado_d       = dado_q;
    escreve      = 1'b0;
    rd_data_d    = mem_q[bus.rd_address];

    if (estado_q == REGISTRA) begin
      // The write always completes; iniciar is honoured on the following cycle.
      escreve      = 1'b1;
      quantidade_d = quantidade_q + 5'd1;
      estado_d     = (quantidade_q == 5'd15) ? CHEIO : SOLTA;
    end else if (bus.iniciar) begin
      quantidade_d = 5'd0;
      estado_d     = estado_inicio;
    end else begin
      case (estado_q)
        ESPERA: begin
          if (botoes_onehot) begin
            dado_d   = bus.botoes;
            estado_d = REGISTRA;
          end else if (!botoes_zero) begin
            estado_d = REJEITA;
          end
        end
        REJEITA: estado_d = SOLTA;
        SOLTA:   if (botoes_zero) estado_d = ESPERA;
        INICIAL, CHEIO: estado_d = estado_q;
        default: estado_d = INICIAL;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= INICIAL;
      quantidade_q <= 5'd0;
      dado_q       <= 4'b0000;
      rd_data_q    <= 4'b0000;
    end else begin
      estado_q     <= estado_d;
      quantidade_q <= quantidade_d;
      dado_q       <= dado_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Memory has no reset; a reset landing in REGISTRA drops the pending write.
  always_ff @(posedge clock) begin
    if (escreve && !reset) begin
      mem_q[quantidade_q[3:0]] <= dado_q;
    end
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.quantidade   = quantidade_q;
  assign bus.jogada_feita = (estado_q == REGISTRA);
  assign bus.erro_jogada  = (estado_q == REJEITA);
  assign bus.cheio        = (estado_q == CHEIO);
  assign bus.gravando     = (estado_q == ESPERA) || (estado_q == REGISTRA) || (estado_q == SOLTA);

endmodule

// File: tb/tb_gravador_sequencia_16x4.sv
// Bench for the sequence recorder: directed scenarios plus random presses,
// all outputs compared every cycle against a flag-based reference model.
module tb_gravador_sequencia_16x4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  gravador_sequencia_16x4_if bus_if ();

  gravador_sequencia_16x4 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: recorded words, count, and what the recorder is doing.
  bit [3:0] m_mem [16];
  bit       m_known [16];
  int       m_count;
  bit       m_active;   // recording and not mid-write/reject
  bit       m_release;  // must see all buttons released before next capture
  bit       m_pend_w;   // a captured press is being written this cycle
  bit       m_pend_e;   // a rejected press is being flagged this cycle
  bit       m_full;
  bit [3:0] m_val;
  bit [3:0] m_rd;
  bit       m_rd_known;

  task automatic model_step(input bit rst, input bit ini, input bit [3:0] b, input bit [3:0] ra);
    bit [3:0] rd_new;
    bit       rd_new_known;
    if (rst) begin
      m_count = 0; m_active = 0; m_release = 0; m_pend_w = 0; m_pend_e = 0;
      m_full = 0; m_rd = 4'b0000; m_rd_known = 1;
      return;
    end
    rd_new       = m_mem[ra];
    rd_new_known = m_known[ra];
    if (m_pend_w) begin
      m_mem[m_count]   = m_val;
      m_known[m_count] = 1;
      m_count++;
      m_pend_w = 0;
      if (m_count == 16) m_full = 1;
      else begin m_active = 1; m_release = 1; end
    end else if (ini) begin
      m_count = 0; m_full = 0; m_pend_e = 0;
      m_active = 1; m_release = (b != 0);
    end else if (m_pend_e) begin
      m_pend_e = 0; m_active = 1; m_release = 1;
    end else if (m_active) begin
      if (m_release) begin
        if (b == 0) m_release = 0;
      end else if (b != 0) begin
        m_active = 0;
        if ($countones(b) == 1) begin m_pend_w = 1; m_val = b; end
        else m_pend_e = 1;
      end
    end
    m_rd = rd_new;
    m_rd_known = rd_new_known;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step(reset, bus_if.iniciar, bus_if.botoes, bus_if.rd_address);
    #1;
    check("quantidade",   32'(bus_if.quantidade),   32'(m_count));
    check("jogada_feita", 32'(bus_if.jogada_feita), 32'(m_pend_w));
    check("erro_jogada",  32'(bus_if.erro_jogada),  32'(m_pend_e));
    check("cheio",        32'(bus_if.cheio),        32'(m_full));
    check("gravando",     32'(bus_if.gravando),     32'(m_active | m_pend_w));
    if (m_rd_known) check("rd_data", 32'(bus_if.rd_data), 32'(m_rd));
  endtask

  task automatic press(input logic [3:0] v, input int hold, input int rel);
    bus_if.botoes = v;
    repeat (hold) begin bus_if.rd_address = 4'($urandom); tick(); end
    bus_if.botoes = 4'b0000;
    repeat (rel) begin bus_if.rd_address = 4'($urandom); tick(); end
  endtask

  task automatic pulse_iniciar();
    bus_if.iniciar = 1'b1;
    tick();
    bus_if.iniciar = 1'b0;
  endtask

  logic [3:0] oh;
  int         pulses;

  initial begin
    for (int i = 0; i < 16; i++) m_known[i] = 0;
    reset = 1'b1;
    bus_if.iniciar    = 1'b0;
    bus_if.botoes     = 4'b0100;
    bus_if.rd_address = 4'd0;

    // Reset with a button held
    repeat (2) tick();
    check("reset_quant", 32'(bus_if.quantidade), 32'd0);
    check("reset_rd",    32'(bus_if.rd_data),    32'd0);
    reset = 1'b0;
    bus_if.botoes = 4'b0000;
    tick();

    // Basic record and readback
    pulse_iniciar();
    press(4'b0001, 3, 2);
    press(4'b0100, 3, 2);
    press(4'b1000, 3, 2);
    check("basic_count", 32'(bus_if.quantidade), 32'd3);
    for (int a = 0; a < 3; a++) begin
      bus_if.rd_address = 4'(a);
      tick();
    end
    check("basic_rd2", 32'(bus_if.rd_data), 32'b1000);

    // Invalid press, then a held press that changes mid-hold
    press(4'b0011, 3, 2);
    check("invalid_count", 32'(bus_if.quantidade), 32'd3);
    pulses = 0;
    bus_if.botoes = 4'b0010;
    repeat (4) begin tick(); pulses += int'(bus_if.jogada_feita); end
    bus_if.botoes = 4'b1010;
    repeat (6) begin tick(); pulses += int'(bus_if.jogada_feita); end
    bus_if.botoes = 4'b0000;
    repeat (2) tick();
    check("held_pulses", 32'(pulses), 32'd1);
    bus_if.rd_address = 4'd3;
    tick(); tick();
    check("held_word", 32'(bus_if.rd_data), 32'b0010);

    // Fill all 16 words, then a 17th press is ignored
    pulse_iniciar();
    for (int i = 0; i < 16; i++) begin
      oh = 4'b0001 << $urandom_range(0, 3);
      press(oh, 2, 1);
    end
    check("fill_cheio", 32'(bus_if.cheio), 32'd1);
    check("fill_count", 32'(bus_if.quantidade), 32'd16);
    press(4'b0100, 3, 2);
    bus_if.rd_address = 4'd0;
    tick(); tick();

    // iniciar while a button is held in SOLTA
    pulse_iniciar();
    bus_if.botoes = 4'b1000;
    repeat (3) tick();
    bus_if.iniciar = 1'b1;
    tick();
    bus_if.iniciar = 1'b0;
    check("restart_count", 32'(bus_if.quantidade), 32'd0);
    repeat (3) tick();
    bus_if.botoes = 4'b0000;
    repeat (2) tick();
    press(4'b0100, 2, 2);
    bus_if.rd_address = 4'd0;
    tick(); tick();
    check("restart_word", 32'(bus_if.rd_data), 32'b0100);

    // Reset while jogada_feita is high: the write must be dropped
    pulse_iniciar();
    bus_if.botoes = 4'b0010;
    tick();
    check("pre_reset_pulse", 32'(bus_if.jogada_feita), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus_if.botoes = 4'b0000;
    bus_if.rd_address = 4'd0;
    tick(); tick();
    check("reset_nowrite", 32'(bus_if.rd_data), 32'b0100);

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      reset          = ($urandom_range(0, 99) == 0);
      bus_if.iniciar = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 19)) inside
          [0:9]:   bus_if.botoes = 4'b0000;
          [10:16]: bus_if.botoes = 4'b0001 << $urandom_range(0, 3);
          default: bus_if.botoes = 4'($urandom);
        endcase
      end
      bus_if.rd_address = 4'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gravador_sequencia_16x4.md
Name: gravador_sequencia_16x4

Overview:
Records the player's button presses into an internal 16x4 synchronous memory, one one-hot 4-bit word per press, in the same format as the game's stored sequence. It sits between the debounced button inputs and the comparison logic. A synchronous read port lets the control unit or a test bench replay or compare the recorded sequence. It detects press/release, rejects non-one-hot codes, counts recorded plays and flags when the memory is full.

Parameters:
None. Geometry is fixed at 16 words x 4 bits, 4-bit address.

Ports:
clock  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
iniciar  input  1  clears the write pointer and starts a new recording; level-sampled
botoes  input  4  button levels, already synchronised and debounced; one-hot when valid
rd_address  input  4  read-port address
rd_data  output  4  read-port data; registered, 1-cycle latency
quantidade  output  5  number of words recorded, 0..16
jogada_feita  output  1  one-cycle pulse when a valid press is written
erro_jogada  output  1  one-cycle pulse when a non-one-hot press is rejected
cheio  output  1  high while 16 words are stored
gravando  output  1  high in ESPERA, REGISTRA and SOLTA

Behaviour:
- Reset (synchronous, active-high): state INICIAL, quantidade=0, rd_data=0, all pulses 0, cheio=0, gravando=0. Memory contents are not cleared.
- FSM states: INICIAL, ESPERA, REGISTRA, REJEITA, SOLTA, CHEIO. Moore outputs.
- INICIAL: idle. If iniciar=1, quantidade<=0 and go to ESPERA when botoes==0, or to SOLTA when botoes!=0. A held button is never captured at start.
- ESPERA: if botoes==0, stay. If botoes is one-hot, latch it into dado_reg and go to REGISTRA. If botoes is nonzero but not one-hot, go to REJEITA.
- REGISTRA (exactly 1 cycle): jogada_feita=1. At the closing edge, mem[quantidade[3:0]]<=dado_reg and quantidade<=quantidade+1. Next state is CHEIO if the pre-increment quantidade was 15; otherwise SOLTA.
- REJEITA (exactly 1 cycle): erro_jogada=1, no write, quantidade unchanged. Next state is SOLTA.
- SOLTA: wait for botoes==0, then go to ESPERA. Any change of buttons while held is ignored, so one press produces one write.
- CHEIO: cheio=1, gravando=0. All presses are ignored and no writes occur. Leave only via iniciar.
- Timing: botoes becomes one-hot before edge k, so the FSM enters REGISTRA at edge k. jogada_feita is high between edge k and edge k+1. The memory word and quantidade update at edge k+1.
- iniciar is honoured in every state except REGISTRA and has priority over the normal transitions. REGISTRA always completes its write, then iniciar is honoured on the next cycle. On iniciar: quantidade<=0, cheio drops, and the next state follows the INICIAL rule.
- Read port: rd_data<=mem[rd_address] every edge, independent of FSM state. A read of the address written in the same cycle returns the old data (read-before-write).
- One-hot check: exactly one bit of the 4 is set.
- quantidade saturates at 16, and 16 is reachable only through CHEIO. The memory address is quantidade[3:0].
- Reset mid-operation: abandons any write not yet clocked, and returns to INICIAL with the reset values above.

Test Plan:
- Reset: assert reset for 2 cycles with botoes=0100 -> state INICIAL, quantidade=0, rd_data=0000, cheio=0, gravando=0, no pulses.
- Basic record: iniciar pulse, then presses 0001, 0100, 1000, each held 3 cycles and released 2 cycles -> 3 jogada_feita pulses, quantidade=3. Reading addresses 0,1,2 gives 0001, 0100, 1000, each one cycle after rd_address is applied.
- Invalid and held: press 0011 -> one erro_jogada pulse, quantidade unchanged. Press 0010 held 10 cycles, changing to 1010 mid-hold -> exactly one write of 0010, one jogada_feita pulse.
- Fill: 16 valid presses -> quantidade=16 and cheio=1 after the 16th write. A 17th press gives no pulse and no write, and address 0 is unchanged.
- iniciar mid-operation with a button held: assert iniciar during SOLTA with botoes=1000 -> quantidade=0. No write until botoes returns to 0000 and a new press arrives, which is written at address 0.
- Reset during REGISTRA: reset in the same cycle as jogada_feita=1 -> quantidade=0 and that target word is not written (verify by reading back the old value).
